// File: rtl/intr_arb_if.sv
// Bus/arm-side signal bundle for the interrupt arbiter.
// master = arbiter side, slave = bus/device side.
interface intr_arb_if;
    logic        armraddr;
    logic [31:0] armrdata;
    logic [3:0]  intreq;
    logic [31:0] irvecs;
    logic        intgnt;
    logic [7:0]  igvec;
    logic        init_in_h;
    logic        bg_in_h;
    logic        bbsy_in_h;
    logic        ssyn_in_h;
    logic        br_out_h;
    logic        sack_out_h;
    logic        bbsy_out_h;
    logic        intr_out_h;
    logic        bg_out_h;
    logic [15:0] d_out_h;

    modport master (
        input  armraddr, intreq, irvecs, init_in_h, bg_in_h, bbsy_in_h, ssyn_in_h,
        output armrdata, intgnt, igvec, br_out_h, sack_out_h, bbsy_out_h,
               intr_out_h, bg_out_h, d_out_h
    );

    modport slave (
        output armraddr, intreq, irvecs, init_in_h, bg_in_h, bbsy_in_h, ssyn_in_h,
        input  armrdata, intgnt, igvec, br_out_h, sack_out_h, bbsy_out_h,
               intr_out_h, bg_out_h, d_out_h
    );
endinterface

// File: rtl/intr_arb.sv
// Interrupt arbiter: picks the lowest-index requesting device and runs the bus interrupt handshake.
// Optional INTR abort timer enabled by defining INTR_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no request latched, bus grant passes down the chain
// REQ   | bus request raised, waiting for bg_in_h
// SACK  | grant acknowledged, waiting for bus to go quiet
// INTR  | bus master, vector driven, waiting for ssyn_in_h
// DONE  | grant issued, waiting for ssyn_in_h to drop
module intr_arb #(
    parameter int NDEV  = 4,
    parameter int TOLIM = 1023
) (
    input  logic      CLOCK,
    input  logic      RESET,
    intr_arb_if.master bus
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] REQ  = 3'd1;
    localparam logic [2:0] SACK = 3'd2;
    localparam logic [2:0] INTR = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    localparam int TW = $clog2(TOLIM + 1);

`ifdef INTR_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic [2:0]    r_state;
    logic [1:0]    r_sel;
    logic [7:0]    r_vec;
    logic          r_intgnt;
    logic [7:0]    r_igvec;
    logic [15:0]   r_gcnt;
    logic [7:0]    r_tocnt;
    logic [TW-1:0] r_tmr;

    logic [NDEV-1:0] w_req;
    logic [1:0]      w_pick_sel;
    logic            w_pick_vld;
    logic            w_tmo;

    assign w_req = bus.intreq;

    // Descending scan so the lowest set index is the last one written.
    always_comb begin
        w_pick_sel = 2'd0;
        w_pick_vld = |w_req;
        for (int i = NDEV - 1; i >= 0; i--) begin
            if (w_req[i]) w_pick_sel = 2'(i);
        end
    end

    // Timer stays in both builds; without the macro its terminal count never takes effect.
    assign w_tmo = TMO_EN && (r_tmr == '0);

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state  <= IDLE;
            r_sel    <= 2'd0;
            r_vec    <= 8'd0;
            r_intgnt <= 1'b0;
            r_igvec  <= 8'd0;
            r_gcnt   <= 16'd0;
            r_tocnt  <= 8'd0;
            r_tmr    <= '0;
        end else begin
            r_intgnt <= 1'b0;
            if (bus.init_in_h) begin
                r_state <= IDLE;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_pick_vld) begin
                            r_sel   <= w_pick_sel;
                            r_vec   <= bus.irvecs[8*w_pick_sel +: 8];
                            r_state <= REQ;
                        end
                    end
                    REQ: begin
                        if (bus.bg_in_h)
                            r_state <= SACK;
                        else if (!bus.intreq[r_sel])
                            r_state <= IDLE;
                    end
                    SACK: begin
                        if (!bus.bg_in_h && !bus.bbsy_in_h && !bus.ssyn_in_h) begin
                            r_tmr   <= TW'(TOLIM - 1);
                            r_state <= INTR;
                        end
                    end
                    INTR: begin
                        if (bus.ssyn_in_h) begin
                            r_intgnt <= 1'b1;
                            r_igvec  <= r_vec;
                            r_gcnt   <= r_gcnt + 16'd1;
                            r_state  <= DONE;
                        end else if (w_tmo) begin
                            r_tocnt <= r_tocnt + 8'd1;
                            r_state <= IDLE;
                        end else begin
                            r_tmr <= r_tmr - TW'(1);
                        end
                    end
                    DONE: begin
                        if (!bus.ssyn_in_h) r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign bus.br_out_h   = (r_state == REQ);
    assign bus.sack_out_h = (r_state == SACK);
    assign bus.bbsy_out_h = (r_state == INTR);
    assign bus.intr_out_h = (r_state == INTR);
    assign bus.d_out_h    = (r_state == INTR) ? {8'b0, r_vec} : 16'd0;
    assign bus.bg_out_h   = (r_state == IDLE) && bus.bg_in_h;
    assign bus.intgnt     = r_intgnt;
    assign bus.igvec      = r_igvec;

    assign bus.armrdata = bus.armraddr ? {r_gcnt, r_tocnt, r_state, r_sel, 3'b000}
                                       : 32'h4941_0001;

endmodule

// File: tb/tb_intr_arb.sv
// Directed bench for intr_arb: expected grant vectors go into a queue, a monitor checks each intgnt pulse.
module tb_intr_arb;
    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] exp_q[$];

    intr_arb_if bus();

    intr_arb #(.NDEV(4), .TOLIM(1023)) u_dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    task automatic rd(input logic a, output logic [31:0] d);
        bus.armraddr = a;
        #1;
        d = bus.armrdata;
    endtask

    // From REQ, walk the bus through SACK, INTR and DONE back to IDLE.
    task automatic hs();
        bus.bg_in_h = 1'b1;   tick();
        bus.bg_in_h = 1'b0;   tick();
        bus.ssyn_in_h = 1'b1; tick();
        bus.ssyn_in_h = 1'b0; tick();
    endtask

    always @(negedge CLOCK) begin
        if (!RESET && bus.intgnt) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL mon_unexpected: got intgnt with igvec %h expected no grant", bus.igvec);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus.igvec !== e) begin
                    n_fail++;
                    $display("FAIL mon_igvec: got %h expected %h", bus.igvec, e);
                end
            end
        end
    end

    initial begin
        logic [31:0] d;
        int n;
        bus.armraddr = 1'b0; bus.intreq = 4'b0; bus.irvecs = 32'h0;
        bus.init_in_h = 1'b0; bus.bg_in_h = 1'b0; bus.bbsy_in_h = 1'b0; bus.ssyn_in_h = 1'b0;
        tick(); tick();
        RESET = 1'b0;

        rd(1'b1, d); chk("rst_rdata1", d, 32'h0);
        rd(1'b0, d); chk("rst_id", d, 32'h4941_0001);
        chk("rst_bus", {bus.br_out_h, bus.sack_out_h, bus.bbsy_out_h, bus.intr_out_h,
                        bus.intgnt, bus.d_out_h}, 32'h0);

        // single request from device 2, vector 8'o100
        bus.irvecs = 32'h3340_1122;
        bus.intreq = 4'b0100;
        exp_q.push_back(8'h40);
        tick();
        chk("A_br", {bus.br_out_h, bus.sack_out_h}, 32'h2);
        rd(1'b1, d); chk("A_state", d, 32'h0000_0030);
        bus.irvecs = 32'hFFFF_FFFF;
        bus.bg_in_h = 1'b1; #1;
        chk("A_bgout_req", bus.bg_out_h, 32'h0);
        tick();
        chk("A_sack", {bus.br_out_h, bus.sack_out_h}, 32'h1);
        bus.bg_in_h = 1'b0; tick();
        chk("A_intr", {bus.bbsy_out_h, bus.intr_out_h, bus.sack_out_h}, 32'h6);
        chk("A_dout", bus.d_out_h, 32'h0040);
        bus.ssyn_in_h = 1'b1; tick();
        chk("A_gnt", {bus.intgnt, bus.igvec}, 32'h140);
        chk("A_rel", {bus.bbsy_out_h, bus.intr_out_h, bus.d_out_h}, 32'h0);
        tick();
        chk("A_pulse", bus.intgnt, 32'h0);
        bus.intreq = 4'b0; bus.ssyn_in_h = 1'b0; tick();
        rd(1'b1, d); chk("A_cnt", d, 32'h0001_0010);

        // simultaneous devices 1 and 3
        bus.irvecs = 32'h3340_1122;
        bus.intreq = 4'b1010;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h33);
        tick();
        rd(1'b1, d); chk("B_sel1", d, 32'h0001_0028);
        hs();
        bus.intreq = 4'b1000; tick();
        rd(1'b1, d); chk("B_sel3", d, 32'h0002_0038);
        hs();
        bus.intreq = 4'b0;
        rd(1'b1, d); chk("B_cnt", d, 32'h0003_0018);

        // request withdrawn before bus grant
        bus.intreq = 4'b0001; tick();
        chk("C_br", bus.br_out_h, 32'h1);
        bus.intreq = 4'b0; tick();
        chk("C_drop", {bus.br_out_h, bus.sack_out_h}, 32'h0);
        rd(1'b1, d); chk("C_state", d, 32'h0003_0000);

        // grant pass-through while idle
        bus.bg_in_h = 1'b1; #1;
        chk("D_bgpass", bus.bg_out_h, 32'h1);
        bus.bg_in_h = 1'b0;

        // INIT during INTR, coincident with ssyn: no grant
        bus.intreq = 4'b0001; tick();
        bus.bg_in_h = 1'b1; tick();
        bus.bg_in_h = 1'b0; tick();
        bus.intreq = 4'b0;
        chk("E_intr", bus.intr_out_h, 32'h1);
        bus.init_in_h = 1'b1; bus.ssyn_in_h = 1'b1; tick();
        chk("E_bus", {bus.br_out_h, bus.sack_out_h, bus.bbsy_out_h, bus.intr_out_h,
                      bus.intgnt, bus.d_out_h}, 32'h0);
        rd(1'b1, d); chk("E_state", d, 32'h0003_0000);
        bus.init_in_h = 1'b0; bus.ssyn_in_h = 1'b0; tick();

`ifdef INTR_ARB_TIMEOUT_EN
        bus.intreq = 4'b0001; tick();
        bus.bg_in_h = 1'b1; tick();
        bus.bg_in_h = 1'b0; tick();
        bus.intreq = 4'b0;
        n = 0;
        while (bus.intr_out_h && n < 2000) begin
            tick();
            n++;
        end
        chk("F_tmo_len", n, 32'd1023);
        chk("F_rel", {bus.bbsy_out_h, bus.intr_out_h, bus.d_out_h, bus.intgnt}, 32'h0);
        rd(1'b1, d); chk("F_tocnt", d, 32'h0003_0100);
`else
        n = 0;
`endif

        // RESET wins over INIT and clears the counters
        bus.intreq = 4'b0100; tick();
        RESET = 1'b1; bus.init_in_h = 1'b1; tick();
        RESET = 1'b0; bus.init_in_h = 1'b0; bus.intreq = 4'b0;
        rd(1'b1, d); chk("G_rst", d, 32'h0);
        chk("G_bus", {bus.br_out_h, bus.intgnt, bus.igvec}, 32'h0);

        tick(); tick();
        chk("q_empty", exp_q.size(), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/intr_arb.md
INTR_ARB -- requirements
Module: intr_arb

Interface
REQ-001 Parameter: NDEV, 4, number of device request inputs, fixed at 4 in this revision.
REQ-002 Parameter: TOLIM, 1023, cycles to wait for ssyn_in_h in INTR before abort (used only with INTR_ARB_TIMEOUT_EN).
REQ-003 CLOCK  in  1  system clock (100 MHz); all state changes on its rising edge.
REQ-004 RESET  in  1  synchronous, active-high reset.
REQ-005 armraddr  in  1  arm register select; armrdata  out  32  arm read data, combinational.
REQ-006 intreq  in  4  per-device interrupt request; irvecs  in  32  device n vector at [8n+7:8n].
REQ-007 intgnt  out  1  one-cycle grant pulse; igvec  out  8  vector granted, valid while intgnt=1.
REQ-008 init_in_h  in  1  bus INIT; bg_in_h  in  1  bus grant in; bbsy_in_h  in  1  bus busy; ssyn_in_h  in  1  slave sync.
REQ-009 br_out_h, sack_out_h, bbsy_out_h, intr_out_h  out  1 each  bus request/ack/busy/interrupt drivers.
REQ-010 bg_out_h  out  1  daisy-chain grant out; d_out_h  out  16  data lines driven with vector.

Function
REQ-011 States, encoded 3 bits: IDLE=0, REQ=1, SACK=2, INTR=3, DONE=4.
REQ-012 IDLE: if any intreq bit set and init_in_h=0, latch lowest-index set bit as sel and its vector, go REQ next cycle; multiple simultaneous requests: lowest index wins.
REQ-013 REQ: br_out_h=1; if intreq[sel] drops before bg_in_h, drop br_out_h and return IDLE without grant.
REQ-014 REQ: on bg_in_h=1, go SACK: sack_out_h=1, br_out_h=0.
REQ-015 SACK: hold sack_out_h; when bg_in_h=0 and bbsy_in_h=0 and ssyn_in_h=0, go INTR.
REQ-016 INTR: bbsy_out_h=1, intr_out_h=1, sack_out_h=0, d_out_h={8'b0, latched vector}.
REQ-017 INTR: on ssyn_in_h=1, pulse intgnt=1 with igvec=latched vector for exactly one cycle, drop intr/bbsy/d_out_h to 0, increment grant counter, go DONE.
REQ-018 DONE: wait ssyn_in_h=0, then IDLE; a new request is not latched before return to IDLE.
REQ-019 bg_out_h = bg_in_h when state is IDLE, else 0 (combinational pass-through; a latched request consumes the grant).
REQ-020 Vector latched in IDLE is used through INTR even if irvecs changes later.
REQ-021 armraddr=0: armrdata=32'h49410001 ([31:16]='IA', [15:12]=0, version 001).
REQ-022 armraddr=1: armrdata={grantcount[15:0], timeoutcount[7:0], state[2:0], sel[1:0], 3'b0}.
REQ-023 Counters are modulo width (grantcount 65535->0, timeoutcount 255->0).
REQ-024 init_in_h=1 in any state: next cycle state IDLE, all bus outputs 0, intgnt 0; counters unaffected.

Reset
REQ-025 RESET: state IDLE, sel 0, intgnt 0, igvec 0, br/sack/bbsy/intr_out_h 0, d_out_h 0, grantcount 0, timeoutcount 0.
REQ-026 RESET takes priority over init_in_h and all other inputs.

Configuration
REQ-027 Macro INTR_ARB_TIMEOUT_EN defined: INTR counts cycles; after TOLIM cycles without ssyn_in_h, drop all bus outputs, no intgnt, increment timeoutcount, go IDLE.
REQ-028 INTR_ARB_TIMEOUT_EN undefined: INTR waits indefinitely; timeoutcount reads constant 0.

Verification
REQ-029 intreq=4'b0100, vec2=8'o100, bg pulse, then ssyn -> br_out_h then sack, d_out_h=16'o000100 with intr_out_h, intgnt pulse 1 cycle with igvec=8'o100, grantcount=1.
REQ-030 intreq=4'b1010 together -> sel=1 granted first; device 3 granted on next full cycle.
REQ-031 intreq[0] raised then dropped before bg_in_h -> br_out_h falls, no intgnt, state IDLE, grantcount unchanged.
REQ-032 idle, bg_in_h=1 -> bg_out_h=1 same cycle; while in REQ, bg_in_h=1 -> bg_out_h=0.
REQ-033 init_in_h pulsed during INTR -> next cycle all bus outputs 0, state 0, no intgnt.
REQ-034 with INTR_ARB_TIMEOUT_EN, no ssyn for 1023 cycles in INTR -> outputs released, timeoutcount=1, armrdata[7:5]=0.
